// File: rtl/seg_scan_driver.sv
// Scans a frame of per-digit cathode bytes onto a common-anode 7-segment bank,
// one active-low anode per slot, with a blanking gap at the head of every slot.
module seg_scan_driver #(
  parameter int unsigned DIGITS          = 8,
  parameter int unsigned TICKS_PER_DIGIT = 100_000,
  parameter int unsigned BLANK_CYCLES    = 1_000,
  parameter logic [7:0]  CAT_OFF         = 8'hFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIGITS*8-1:0]         display,
  input  logic [DIGITS-1:0]           digit_mask,
  output logic [DIGITS-1:0]           an,
  output logic [7:0]                  cathode,
  output logic                        frame_start,
  output logic [$clog2(DIGITS)-1:0]   digit_idx
);

  localparam int unsigned IDX_W  = $clog2(DIGITS);
  localparam int unsigned TICK_W = $clog2(TICKS_PER_DIGIT);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_DIGIT - 1);
  localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);

  if (DIGITS < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= TICKS_PER_DIGIT) begin : g_param_err
    $error("seg_scan_driver: need DIGITS>=2 and 1 <= BLANK_CYCLES < TICKS_PER_DIGIT");
  end

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state;
  logic                run;
  logic [TICK_W-1:0]   tick;
  logic [7:0]          fbuf [DIGITS];
  logic [DIGITS-1:0]   mbuf;
  logic                snap_c;

  // Frame boundary: the first edge out of reset, or the end of the last digit's slot.
  assign snap_c = !run || (tick == TICK_LAST && digit_idx == IDX_LAST);

  // Frame snapshot so a mid-frame display update can never tear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DIGITS); i++) fbuf[i] <= CAT_OFF;
      mbuf <= '0;
    end else if (snap_c) begin
      for (int i = 0; i < int'(DIGITS); i++) fbuf[i] <= display[i*8 +: 8];
      mbuf <= digit_mask;
    end
  end

  // Slot sequencer with registered anode/cathode drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BLANK;
      run         <= 1'b0;
      tick        <= '0;
      digit_idx   <= '0;
      an          <= '1;
      cathode     <= CAT_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= snap_c;
      if (!run) begin
        run <= 1'b1;
      end else if (tick == TICK_LAST) begin
        tick      <= '0;
        state     <= BLANK;
        an        <= '1;
        cathode   <= CAT_OFF;
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
        if (state == BLANK && tick == BLANK_LAST) begin
          state   <= SHOW;
          cathode <= fbuf[digit_idx];
          an      <= ~(DIGITS'(mbuf[digit_idx]) << digit_idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a cycle-indexed reference model pushes
// the expected outputs of every cycle into a scoreboard that is checked after each edge.
module tb_seg_scan_driver;

  localparam int unsigned D = 4;
  localparam int unsigned T = 10;
  localparam int unsigned B = 2;
  localparam int unsigned FRAME = D * T;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   display = 32'h11_22_33_44;
  logic [3:0]    digit_mask = 4'hF;
  logic [3:0]    an;
  logic [7:0]    cathode;
  logic          frame_start;
  logic [1:0]    digit_idx;

  int checks = 0;
  int errors = 0;
  int cyc = -1;
  int last_fs = -1;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] cat;
    logic       fs;
    logic [1:0] idx;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] snap_disp = 32'hFFFF_FFFF;
  logic [3:0]  snap_mask = 4'h0;

  seg_scan_driver #(
    .DIGITS(D), .TICKS_PER_DIGIT(T), .BLANK_CYCLES(B), .CAT_OFF(8'hFF)
  ) dut (
    .clk(clk), .rst(rst), .display(display), .digit_mask(digit_mask),
    .an(an), .cathode(cathode), .frame_start(frame_start), .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: push expectation at each edge, compare 1 time unit later.
  always @(posedge clk) begin
    exp_t e;
    int   slot, pos;
    if (!rst) begin
      cyc = -1;
      last_fs = -1;
      snap_disp = 32'hFFFF_FFFF;
      snap_mask = 4'h0;
      e = '{an: 4'hF, cat: 8'hFF, fs: 1'b0, idx: 2'd0};
    end else begin
      cyc++;
      slot = (cyc / T) % D;
      pos  = cyc % T;
      if (slot == 0 && pos == 0) begin
        snap_disp = display;
        snap_mask = digit_mask;
      end
      e.fs  = (slot == 0 && pos == 0);
      e.idx = 2'(slot);
      if (pos < int'(B)) begin
        e.an  = 4'hF;
        e.cat = 8'hFF;
      end else begin
        e.cat = snap_disp[slot*8 +: 8];
        e.an  = snap_mask[slot] ? ~(4'b0001 << slot) : 4'hF;
      end
    end
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check("an", 32'(an), 32'(e.an));
    check("cathode", 32'(cathode), 32'(e.cat));
    check("frame_start", 32'(frame_start), 32'(e.fs));
    check("digit_idx", 32'(digit_idx), 32'(e.idx));
    check("an_one_low", 32'($countones(~an) <= 1), 32'd1);
    if (frame_start === 1'b1 && rst) begin
      if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(FRAME));
      last_fs = cyc;
    end
  end

  // Advance to a given model cycle index, landing 2 units after its opening edge.
  task automatic goto(input int t);
    if (t > cyc) begin
      repeat (t - cyc) @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] a, input logic [7:0] c);
    check({tag, "_an"}, 32'(an), 32'(a));
    check({tag, "_cat"}, 32'(cathode), 32'(c));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    goto(0);
  endtask

  initial begin
    // Scenario 1: reset then release.
    repeat (3) @(posedge clk);
    #2;
    expect_out("reset", 4'hF, 8'hFF);
    check("reset_idx", 32'(digit_idx), 32'd0);
    check("reset_fs", 32'(frame_start), 32'd0);
    release_reset();
    check("s1_fs", 32'(frame_start), 32'd1);
    expect_out("s1_c0", 4'hF, 8'hFF);
    goto(1);  expect_out("s1_c1", 4'hF, 8'hFF);
    goto(2);  expect_out("s1_c2", 4'hE, 8'h44);
    goto(9);  expect_out("s1_c9", 4'hE, 8'h44);
    goto(10); expect_out("s1_c10", 4'hF, 8'hFF);
    goto(12); expect_out("s1_c12", 4'hD, 8'h33);

    // Scenario 3: mid-frame display change lands only at the next frame.
    goto(15); display = 32'hAA_BB_CC_DD;
    goto(22); expect_out("s3_slot2", 4'hB, 8'h22);
    goto(42); expect_out("s3_next", 4'hE, 8'hDD);
    goto(49); expect_out("s3_next_end", 4'hE, 8'hDD);

    // Scenario 4: masked digits stay dark but still drive their cathodes.
    goto(50); digit_mask = 4'b0101;
    goto(85);  expect_out("s4_slot0", 4'hE, 8'hDD);
    goto(95);  expect_out("s4_slot1", 4'hF, 8'hCC);
    goto(105); expect_out("s4_slot2", 4'hB, 8'hBB);
    goto(115); expect_out("s4_slot3", 4'hF, 8'hAA);

    // Scenario 5: async reset during SHOW of slot 2.
    display = 32'h11_22_33_44;
    digit_mask = 4'hF;
    goto(120);
    goto(145);
    rst = 1'b0;
    #1;
    expect_out("s5_async", 4'hF, 8'hFF);
    check("s5_idx", 32'(digit_idx), 32'd0);
    check("s5_fs", 32'(frame_start), 32'd0);
    repeat (2) @(posedge clk);
    release_reset();
    check("s5_fs_again", 32'(frame_start), 32'd1);
    goto(2);  expect_out("s5_c2", 4'hE, 8'h44);
    goto(10); expect_out("s5_c10", 4'hF, 8'hFF);
    goto(12); expect_out("s5_c12", 4'hD, 8'h33);

    // Scenario 6: random display/mask churn for 1000 frames.
    goto(FRAME);
    for (int i = 0; i < 1000 * int'(FRAME); i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 19) == 0) begin
        display    = $urandom;
        digit_mask = 4'($urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
